cronometro_bcd: RTL and testbench
=================================

// Module: cronometro_bcd
// PURPOSE
//  Parametrised stopwatch core: debounced active-low buttons, tick prescaler,
//  N-digit BCD counter with lap (split) freeze, pause/resume and overflow policy.
//  Drives BCD digits straight to the per-digit decodificador instances.
//  No binary-to-BCD conversion stage is needed.
// PARAMETERS
//  TICK_DIV    5000000  clk cycles per count step (0.1 s at 50 MHz)
//  N_DIGITS    4        number of BCD digits (1..8)
//  DEB_CYCLES  500000   stable-level cycles needed to accept a button edge
//  WRAP        1        1: all-9s wraps to 0; 0: saturate at all-9s and halt
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  btn_start_n  in   1            raw button, active-low: start/resume
//  btn_lap_n    in   1            raw button, active-low: lap freeze/release
//  btn_stop_n   in   1            raw button, active-low: pause
//  btn_clear_n  in   1            raw button, active-low: clear to zero
//  bcd_out      out  4*N_DIGITS   displayed value; digit k = bits [4k+3:4k], k=0 LSD
//  running      out  1            1 in RUN or LAP
//  lap_active   out  1            1 in LAP (display frozen)
//  overflow     out  1            sticky; set on all-9s rollover/saturation
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, count=0, prescaler=0, bcd_out=0,
//    running=0, lap_active=0, overflow=0, debouncers report released.
//  - Buttons: 2-flop synchroniser, then debouncer; level accepted after
//    DEB_CYCLES consecutive equal samples. One-cycle press pulse on accepted
//    1->0 transition only; holding a button gives exactly one pulse.
//  - Simultaneous pulses, priority: clear > stop > lap > start.
//  - FSM: IDLE, RUN, LAP, STOP.
//    IDLE: start->RUN. lap, stop: ignored.
//    RUN:  stop->STOP; lap->LAP, capture count into lap register.
//    LAP:  lap->RUN; stop->STOP. Counting continues.
//    STOP: start->RUN. lap: ignored.
//    Any state: clear->IDLE, count=0, prescaler=0, overflow=0.
//  - Prescaler: 0..TICK_DIV-1; advances only in RUN/LAP; held in STOP, so
//    resume keeps the partial interval; zeroed in IDLE. tick=1 for one cycle
//    when prescaler==TICK_DIV-1, then prescaler returns to 0.
//  - BCD count: on tick, LSD+1; digit 9->0 carries to next digit in the same
//    cycle. Digits never hold 10..15.
//    All-9s + tick: WRAP=1 -> all 0s, overflow=1, keep running.
//    WRAP=0 -> hold all-9s, overflow=1, FSM->STOP.
//  - bcd_out registered, 1-cycle latency: count in RUN/STOP/IDLE,
//    lap register in LAP.
//  - Tick and lap press in same cycle: lap register captures pre-increment count.
//  - Clear and tick in same cycle: clear wins; count=0.
// STRUCTURE
//  - Shared include cronometro_defs.vh: FSM state localparams
//    (IDLE=0, RUN=1, LAP=2, STOP=3) and the BCD digit width (4).
//  - Sub-module btn_debounce (parameter DEB_CYCLES): synchroniser, debouncer
//    and press-pulse generator. Four instances, one per button.
//  - Prescaler, BCD counter (generate loop over N_DIGITS), FSM and output
//    register stay in this module.
// TESTING (TICK_DIV=4, DEB_CYCLES=2, N_DIGITS=2 unless stated)
//  1 Reset mid-run: start, 5 ticks, assert rst_n=0 between edges -> all
//    outputs 0 immediately, asynchronously.
//  2 Count/carry: start, 10 ticks -> bcd_out=8'h10; 99 ticks from 0 -> 8'h99,
//    never 8'h0A..8'h0F.
//  3 Lap: start, 7 ticks, lap -> bcd_out frozen 8'h07, lap_active=1; 5 more
//    ticks, lap -> bcd_out=8'h12.
//  4 Pause/resume: stop 2 cycles into a tick interval, wait 100 cycles -> value
//    held; start -> next increment 2 cycles later.
//  5 Overflow: WRAP=1, 100 ticks -> 8'h00, overflow=1, running=1;
//    WRAP=0 -> 8'h99, overflow=1, running=0. Clear -> IDLE, overflow=0.
//  6 Buttons: glitch low 1 cycle -> no action; clear+start pressed together
//    in RUN -> IDLE, bcd_out=0; start held 50 cycles -> one pulse only.

Source files
------------

// File: rtl/cronometro_bcd_pkg.sv
// Shared definitions for the stopwatch core: FSM states, BCD digit width, digit increment.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cronometro_bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // One BCD digit plus one; 9 (or any illegal code) rolls to 0.
    function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/cronometro_bcd_debounce.sv
// Button conditioner: 2-flop synchroniser, level debouncer, one-cycle press pulse on accepted 1->0.
// Latency: press pulse appears 2 + DEB_CYCLES cycles after the raw level settles low.
// Backpressure: none; a held button yields exactly one pulse, glitches shorter than DEB_CYCLES are dropped.
//   clk, rst_n : clock, async active-low reset (level reports released)
//   btn_n      : raw active-low button
//   press      : registered one-cycle pulse
module cronometro_bcd_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronised samples that differ from the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cronometro_bcd.sv
// Stopwatch core: debounced buttons, tick prescaler, N-digit BCD counter with lap freeze, pause and overflow.
// Latency: outputs registered, one cycle behind internal state; buttons add 3 + DEB_CYCLES cycles.
// Backpressure: none; simultaneous presses resolved clear > stop > lap > start.
//   clk, rst_n                         : clock, async active-low reset
//   btn_start_n/lap_n/stop_n/clear_n   : raw active-low buttons
//   bcd_out    : displayed value, digit k at [4k+3:4k], k=0 least significant
//   running    : RUN or LAP;  lap_active : LAP (display frozen);  overflow : sticky all-9s rollover
module cronometro_bcd
    import cronometro_bcd_pkg::*;
#(
    parameter int TICK_DIV   = 5000000,
    parameter int N_DIGITS   = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int WRAP       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_start_n,
    input  logic                      btn_lap_n,
    input  logic                      btn_stop_n,
    input  logic                      btn_clear_n,
    output logic [BCD_W*N_DIGITS-1:0] bcd_out,
    output logic                      running,
    output logic                      lap_active,
    output logic                      overflow
);
    localparam int CNT_W = BCD_W * N_DIGITS;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic press_start, press_lap, press_stop, press_clear;
    logic go_stop, go_lap, go_start;

    cronometro_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_start_n), .press(press_start));
    cronometro_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_lap_n), .press(press_lap));
    cronometro_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_stop_n), .press(press_stop));
    cronometro_bcd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_clear_n), .press(press_clear));

    // Only the highest-priority press is acted on; clear is handled ahead of these.
    assign go_stop  = press_stop;
    assign go_lap   = press_lap & ~press_stop;
    assign go_start = press_start & ~press_stop & ~press_lap;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  lap_reg;
    logic              ovf_flag;
    logic              counting;
    logic              tick;
    logic              all_nines;
    logic [N_DIGITS:0] carry;

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (presc == PRE_LAST);

    // Ripple carry across digits in one cycle; all-9s naturally rolls to all-0s.
    assign carry[0] = 1'b1;
    genvar k;
    generate
        for (k = 0; k < N_DIGITS; k++) begin : g_digit
            logic [BCD_W-1:0] d;
            assign d = count[BCD_W*k +: BCD_W];
            assign count_inc[BCD_W*k +: BCD_W] = carry[k] ? bcd_digit_inc(d) : d;
            assign carry[k+1] = carry[k] && (d == 4'd9);
        end
    endgenerate
    assign all_nines = carry[N_DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            count      <= '0;
            lap_reg    <= '0;
            ovf_flag   <= 1'b0;
            bcd_out    <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            bcd_out    <= (state == ST_LAP) ? lap_reg : count;
            running    <= counting;
            lap_active <= (state == ST_LAP);
            overflow   <= ovf_flag;

            if (press_clear) begin
                // Clear beats a coincident tick.
                state    <= ST_IDLE;
                presc    <= '0;
                count    <= '0;
                ovf_flag <= 1'b0;
            end else begin
                // STOP holds the partial interval so resume is seamless.
                if (counting) begin
                    presc <= tick ? '0 : presc + 1'b1;
                end else if (state == ST_IDLE) begin
                    presc <= '0;
                end

                if (tick) begin
                    if (all_nines) begin
                        ovf_flag <= 1'b1;
                    end
                    if (!all_nines || WRAP != 0) begin
                        count <= count_inc;
                    end
                end

                case (state)
                    ST_IDLE: if (go_start) state <= ST_RUN;
                    ST_RUN: begin
                        if (go_stop) begin
                            state <= ST_STOP;
                        end else if (go_lap) begin
                            state   <= ST_LAP;
                            lap_reg <= count;   // pre-increment value if a tick coincides
                        end
                    end
                    ST_LAP: begin
                        if (go_stop) state <= ST_STOP;
                        else if (go_lap) state <= ST_RUN;
                    end
                    ST_STOP: if (go_start) state <= ST_RUN;
                    default: state <= ST_IDLE;
                endcase

                // Saturating mode halts on reaching all-9s regardless of buttons.
                if (tick && all_nines && WRAP == 0) begin
                    state <= ST_STOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_cronometro_bcd.sv
module tb_cronometro_bcd;
    localparam int TD  = 4;
    localparam int ND  = 2;
    localparam int DEB = 2;
    localparam int MOD = 100;
    localparam int LAT = 3 + DEB;   // edges from driving a button to the FSM acting on it

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_start_n = 1'b1, btn_lap_n = 1'b1, btn_stop_n = 1'b1, btn_clear_n = 1'b1;
    logic [7:0] bcd_w, bcd_s;
    logic run_w, lap_w, ovf_w, run_s, lap_s, ovf_s;

    always #5 clk = ~clk;

    cronometro_bcd #(.TICK_DIV(TD), .N_DIGITS(ND), .DEB_CYCLES(DEB), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start_n(btn_start_n), .btn_lap_n(btn_lap_n),
        .btn_stop_n(btn_stop_n), .btn_clear_n(btn_clear_n), .bcd_out(bcd_w),
        .running(run_w), .lap_active(lap_w), .overflow(ovf_w));

    cronometro_bcd #(.TICK_DIV(TD), .N_DIGITS(ND), .DEB_CYCLES(DEB), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .btn_start_n(btn_start_n), .btn_lap_n(btn_lap_n),
        .btn_stop_n(btn_stop_n), .btn_clear_n(btn_clear_n), .bcd_out(bcd_s),
        .running(run_s), .lap_active(lap_s), .overflow(ovf_s));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: elapsed time is the number of active (RUN/LAP) cycles since clear;
    // the displayed count is that divided by TD, modulo 10^ND.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_LAP, M_STOP} mmode_t;
    mmode_t     m_mode = M_IDLE;
    longint     m_act = 0;
    int         m_lap_val = 0;
    int         cyc = 0;
    int         last_rel = 0;
    int         pend [4] = '{-1, -1, -1, -1};   // edge at which each button's press takes effect
    logic [7:0] exp_bcd = 8'h00;
    logic       exp_run = 1'b0, exp_lap = 1'b0, exp_ovf = 1'b0;

    logic f_start, f_lap, f_stop, f_clear, m_counting;
    int   m_val;
    assign f_start    = (pend[0] == cyc + 1);
    assign f_lap      = (pend[1] == cyc + 1);
    assign f_stop     = (pend[2] == cyc + 1);
    assign f_clear    = (pend[3] == cyc + 1);
    assign m_counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    assign m_val      = int'((m_act / TD) % MOD);

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= M_IDLE;
            m_act     <= 0;
            m_lap_val <= 0;
            exp_bcd   <= 8'h00;
            exp_run   <= 1'b0;
            exp_lap   <= 1'b0;
            exp_ovf   <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            exp_bcd <= (m_mode == M_LAP) ? to_bcd(m_lap_val) : to_bcd(m_val);
            exp_run <= m_counting;
            exp_lap <= (m_mode == M_LAP);
            exp_ovf <= (m_act / TD) >= MOD;
            if (f_clear) begin
                m_mode <= M_IDLE;
                m_act  <= 0;
            end else begin
                if (m_counting) m_act <= m_act + 1;
                if (f_stop) begin
                    if (m_counting) m_mode <= M_STOP;
                end else if (f_lap) begin
                    if (m_mode == M_RUN) begin
                        m_mode    <= M_LAP;
                        m_lap_val <= m_val;
                    end else if (m_mode == M_LAP) begin
                        m_mode <= M_RUN;
                    end
                end else if (f_start && (m_mode == M_IDLE || m_mode == M_STOP)) begin
                    m_mode <= M_RUN;
                end
            end
        end
    end

    logic [10:0] obs, expv;
    assign obs  = {bcd_w, run_w, lap_w, ovf_w};
    assign expv = {exp_bcd, exp_run, exp_lap, exp_ovf};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Drives the masked buttons (bit0 start, 1 lap, 2 stop, 3 clear) low for 'hold' edges.
    task automatic press(input logic [3:0] mask, input int hold, output int act);
        wait_to(last_rel + DEB + 4);
        act = cyc + LAT;
        for (int b = 0; b < 4; b++) if (mask[b]) pend[b] = act;
        {btn_clear_n, btn_stop_n, btn_lap_n, btn_start_n} = ~mask;
        repeat (hold) step();
        {btn_clear_n, btn_stop_n, btn_lap_n, btn_start_n} = 4'hF;
        last_rel = cyc;
    endtask

    task automatic test_reset();
        int a;
        repeat (3) step();
        vectors++;
        if ({obs, bcd_s, run_s, lap_s, ovf_s} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%h want all zero", obs, {bcd_s, run_s, lap_s, ovf_s});
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        press(4'b0001, 3, a);
        wait_to(a + 4 * 5 + 1);
        vectors++;
        if (obs !== {8'h05, 3'b100}) begin
            miscompares++;
            $display("FAIL run_5_ticks: got bcd=%h flags=%b want bcd=05 flags=100", obs[10:3], obs[2:0]);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({obs, bcd_s, run_s, lap_s, ovf_s} !== 22'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h/%h want all zero", obs, {bcd_s, run_s, lap_s, ovf_s});
        end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_count();
        int a;
        press(4'b1000, 3, a);
        press(4'b0001, 3, a);
        while (cyc < a + 4 * 99 + 1) begin
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL count_model cyc=%0d: got bcd=%h flags=%b want bcd=%h flags=%b",
                         cyc, obs[10:3], obs[2:0], expv[10:3], expv[2:0]);
            end
            vectors++;
            if (bcd_w[3:0] > 4'd9 || bcd_w[7:4] > 4'd9) begin
                miscompares++;
                $display("FAIL digit_range: got %h want digits 0..9", bcd_w);
            end
            if (cyc == a + 41) begin
                vectors++;
                if (bcd_w !== 8'h10) begin
                    miscompares++;
                    $display("FAIL carry_10: got %h want 10", bcd_w);
                end
            end
        end
        vectors++;
        if (obs !== {8'h99, 3'b100}) begin
            miscompares++;
            $display("FAIL count_99: got bcd=%h flags=%b want bcd=99 flags=100", obs[10:3], obs[2:0]);
        end
    endtask

    task automatic test_lap();
        int a, l;
        press(4'b1000, 3, a);
        press(4'b0001, 3, a);
        wait_to(a + 25);
        press(4'b0010, 3, l);
        wait_to(a + 31);
        vectors++;
        if (obs !== {8'h07, 3'b110} || obs !== expv) begin
            miscompares++;
            $display("FAIL lap_freeze: got bcd=%h flags=%b want bcd=07 flags=110", obs[10:3], obs[2:0]);
        end
        wait_to(a + 44);
        vectors++;
        if (obs !== {8'h07, 3'b110}) begin
            miscompares++;
            $display("FAIL lap_held: got bcd=%h flags=%b want bcd=07 flags=110", obs[10:3], obs[2:0]);
        end
        wait_to(a + 45);
        press(4'b0010, 3, l);
        wait_to(a + 51);
        vectors++;
        if (obs !== {8'h12, 3'b100} || obs !== expv) begin
            miscompares++;
            $display("FAIL lap_release: got bcd=%h flags=%b want bcd=12 flags=100", obs[10:3], obs[2:0]);
        end
    endtask

    task automatic test_pause();
        int a, p, s;
        press(4'b1000, 3, a);
        press(4'b0001, 3, a);
        wait_to(a + 9);
        press(4'b0100, 3, p);     // takes effect 2 cycles into the 4th interval
        wait_to(a + 15);
        repeat (100) begin
            step();
            vectors++;
            if (obs !== {8'h03, 3'b000} || obs !== expv) begin
                miscompares++;
                $display("FAIL pause_hold cyc=%0d: got bcd=%h flags=%b want bcd=03 flags=000",
                         cyc, obs[10:3], obs[2:0]);
            end
        end
        press(4'b0001, 3, s);
        wait_to(s + 2);
        vectors++;
        if (obs !== {8'h03, 3'b100}) begin
            miscompares++;
            $display("FAIL resume_pre: got bcd=%h flags=%b want bcd=03 flags=100", obs[10:3], obs[2:0]);
        end
        step();
        vectors++;
        if (obs !== {8'h04, 3'b100} || obs !== expv) begin
            miscompares++;
            $display("FAIL resume_step: got bcd=%h flags=%b want bcd=04 flags=100", obs[10:3], obs[2:0]);
        end
    endtask

    task automatic test_overflow();
        int a, c;
        press(4'b1000, 3, a);
        press(4'b0001, 3, a);
        while (cyc < a + 4 * 100 + 1) begin
            step();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL ovf_model cyc=%0d: got bcd=%h flags=%b want bcd=%h flags=%b",
                         cyc, obs[10:3], obs[2:0], expv[10:3], expv[2:0]);
            end
        end
        vectors++;
        if (obs !== {8'h00, 3'b101}) begin
            miscompares++;
            $display("FAIL wrap_overflow: got bcd=%h flags=%b want bcd=00 flags=101", obs[10:3], obs[2:0]);
        end
        vectors++;
        if ({bcd_s, run_s, lap_s, ovf_s} !== {8'h99, 3'b001}) begin
            miscompares++;
            $display("FAIL saturate_overflow: got bcd=%h flags=%b want bcd=99 flags=001",
                     bcd_s, {run_s, lap_s, ovf_s});
        end
        press(4'b1000, 3, c);
        wait_to(c + 1);
        vectors++;
        if ({obs, bcd_s, run_s, lap_s, ovf_s} !== 22'h0) begin
            miscompares++;
            $display("FAIL clear_overflow: got %h/%h want all zero", obs, {bcd_s, run_s, lap_s, ovf_s});
        end
    endtask

    task automatic test_buttons();
        int a, x, l;
        press(4'b1000, 3, a);
        wait_to(last_rel + DEB + 4);
        btn_start_n = 1'b0;
        step();
        btn_start_n = 1'b1;
        last_rel = cyc;
        repeat (12) begin
            step();
            vectors++;
            if (obs !== {8'h00, 3'b000} || obs !== expv) begin
                miscompares++;
                $display("FAIL glitch_ignored: got bcd=%h flags=%b want bcd=00 flags=000", obs[10:3], obs[2:0]);
            end
        end
        press(4'b0001, 3, a);
        wait_to(a + 10);
        press(4'b1001, 3, x);
        wait_to(x + 1);
        vectors++;
        if (obs !== {8'h00, 3'b000} || obs !== expv) begin
            miscompares++;
            $display("FAIL clear_beats_start: got bcd=%h flags=%b want bcd=00 flags=000", obs[10:3], obs[2:0]);
        end
        press(4'b0001, 50, a);
        press(4'b0010, 50, l);
        repeat (12) begin
            step();
            vectors++;
            if (lap_w !== 1'b1 || run_w !== 1'b1 || obs !== expv) begin
                miscompares++;
                $display("FAIL held_one_pulse: got bcd=%h flags=%b want flags=11x model bcd=%h",
                         obs[10:3], obs[2:0], expv[10:3]);
            end
        end
    endtask

    task automatic test_random();
        int act, gap, hold;
        logic [3:0] mask;
        for (int it = 0; it < 40; it++) begin
            gap = $urandom_range(0, 15);
            repeat (gap) begin
                step();
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL random_model it=%0d cyc=%0d: got bcd=%h flags=%b want bcd=%h flags=%b",
                             it, cyc, obs[10:3], obs[2:0], expv[10:3], expv[2:0]);
                end
            end
            if ($urandom_range(0, 9) == 0) mask = 4'b1000;
            else mask = 4'b0001 << $urandom_range(0, 2);
            hold = $urandom_range(3, 8);
            press(mask, hold, act);
            wait_to(act + 1);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_action it=%0d mask=%b: got bcd=%h flags=%b want bcd=%h flags=%b",
                         it, mask, obs[10:3], obs[2:0], expv[10:3], expv[2:0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count();
        test_lap();
        test_pause();
        test_overflow();
        test_buttons();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
